mux_scan_ctrl: RTL

Sequential scan controller that sits in front of the 16:1 mux tree. It drives the four select lines (a, b, c, d) through channels 0..15 and holds each code for a settle window. At the end of each window it samples the mux output y, then publishes the 16 sampled bits as one frame. It is the select-generation stage that feeds the 4:1 mux slices and consumes their combined output.

---
 rtl/mux_scan_ctrl_pkg.sv | 28 ++
 rtl/mux_scan_ctrl_if.sv | 33 +++
 rtl/mux_scan_ctrl_dwell_timer.sv | 31 +++
 rtl/mux_scan_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the mux scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Holds the FSM state encoding, select/frame widths and a small helper
// used by the controller to recognise the last channel of a frame.
package mux_scan_ctrl_pkg;

    localparam int SEL_W  = 4;   // select code width {a,b,c,d}
    localparam int NUM_CH = 16;  // channels per frame, fixed by the 4-bit select
    localparam int CNT_W  = 8;   // dwell counter width, covers DWELL up to 255

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef logic [SEL_W-1:0]  ch_t;
    typedef logic [NUM_CH-1:0] frame_t;

    // True on the channel whose sample completes the frame.
    function automatic logic is_last_ch(input ch_t ch);
        return ch == ch_t'(NUM_CH - 1);
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bundle of control, select and frame signals between scan controller and its user.
// Latency: n/a (wiring only).
// Backpressure: none; the controller never stalls and the frame is a held register.
//
// master: drives start/cont/abort and the mux output y; observes selects,
//         busy, done and frame.
// slave : the scan controller itself.
interface mux_scan_ctrl_if;
    import mux_scan_ctrl_pkg::*;

    logic   start;  // begin a frame scan (IDLE only)
    logic   cont;   // continuous mode, sampled in DONE
    logic   abort;  // cancel the scan, return to IDLE next cycle
    logic   y;      // combined 16:1 mux output
    logic   a;      // select bit 3
    logic   b;      // select bit 2
    logic   c;      // select bit 1
    logic   d;      // select bit 0
    logic   busy;   // high in SETTLE and SAMPLE
    logic   done;   // one-cycle pulse when a frame completes
    frame_t frame;  // last completed frame

    modport master (
        output start, cont, abort, y,
        input  a, b, c, d, busy, done, frame
    );

    modport slave (
        input  start, cont, abort, y,
        output a, b, c, d, busy, done, frame
    );

endinterface

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Settle-window counter: counts cycles while enabled, flags the last one.
// Latency: expire is combinational from the count register (same cycle).
// Backpressure: none; clear dominates enable.
//
// Ports: clk, rst (sync, active-high), clr (zero the count), en (advance),
//        expire (count has reached DWELL-1).
module dwell_timer
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 2   // legal 1..255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == CNT_W'(DWELL - 1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller stepping a 16:1 mux select through all channels and framing the samples.
// Latency: frame published 16*(DWELL+1)+1 cycles after start is accepted.
// Backpressure: none; start is ignored while a scan is in progress, abort wins over everything but rst.
//
// Ports: clk, rst (sync, active-high), bus (mux_scan_ctrl_if.slave):
//   start/cont/abort/y in; a,b,c,d selects, busy, done pulse, frame out.
// The channel register drives the selects directly so they never glitch.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 2   // settle cycles per channel, legal 1..255
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_ctrl_if.slave  bus
);

    state_t state;
    ch_t    ch;
    frame_t shadow;
    frame_t shadow_upd;
    frame_t frame_q;
    logic   busy_q;
    logic   done_q;
    logic   dwell_expire;

    // The timer only runs in SETTLE; holding it clear everywhere else means
    // every SETTLE entry starts from zero without extra bookkeeping.
    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != ST_SETTLE),
        .en     (state == ST_SETTLE),
        .expire (dwell_expire)
    );

    // Shadow with the current sample merged in, so the final channel's bit
    // lands in the published frame on the same edge it is captured.
    always_comb begin
        shadow_upd     = shadow;
        shadow_upd[ch] = bus.y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ch      <= '0;
            shadow  <= '0;
            frame_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ch <= '0;
                    if (bus.start && !bus.abort) begin
                        state  <= ST_SETTLE;
                        busy_q <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (bus.abort) begin
                        state  <= ST_IDLE;
                        ch     <= '0;
                        busy_q <= 1'b0;
                    end else if (dwell_expire) begin
                        state <= ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    if (bus.abort) begin
                        state  <= ST_IDLE;
                        ch     <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        shadow <= shadow_upd;
                        if (is_last_ch(ch)) begin
                            // Selects drop to 0 with DONE so every code,
                            // including 15, is presented for DWELL+1 cycles.
                            state   <= ST_DONE;
                            ch      <= '0;
                            frame_q <= shadow_upd;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state <= ST_SETTLE;
                            ch    <= ch + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    ch <= '0;
                    if (bus.cont && !bus.abort) begin
                        state  <= ST_SETTLE;
                        busy_q <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    ch     <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d} = ch;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.frame = frame_q;

endmodule
